// File: rtl/seg_dyn_scan_ctrl.sv
// seg_dyn_scan_ctrl
//   Drives a 6-digit multiplexed seven-segment display from a binary display
//   bus. A free-running shift-add-3 engine converts the 20-bit value to six
//   BCD digits and publishes them, together with point and sign, into shadow
//   registers in one atomic update every 22 cycles. The scan logic shows one
//   digit per slot and applies leading-zero blanking, decimal points and the
//   minus sign.
//
// Ports
//   sys_clk    system clock
//   sys_rst_n  asynchronous reset, active low
//   data       unsigned value to display (clamped to 999_999)
//   point      decimal-point enables, bit i = digit i (digit 0 rightmost)
//   sign       1 = show a minus sign left of the leftmost shown digit
//   seg_en     1 = display on, 0 = all blank
//   sel        one-hot digit select, active high
//   seg        segment drive, active low, seg[7]=dp, seg[6:0]=g..a
module seg_dyn_scan_ctrl #(
  parameter int CNT_SCAN_MAX = 49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam int CW = (CNT_SCAN_MAX > 0) ? $clog2(CNT_SCAN_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX_C = CW'(CNT_SCAN_MAX);
  localparam logic [19:0]   DATA_MAX  = 20'd999_999;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LOAD} conv_st_t;

  // ---------------------------------------------------------------- scan
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_MAX_C) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // ----------------------------------------------------------- converter
  conv_st_t    state_q, state_d;
  logic [19:0] bin_q, bin_d;
  logic [23:0] bcd_q, bcd_d, bcd_adj;
  logic [5:0]  wpt_q, wpt_d;
  logic        wsgn_q, wsgn_d;
  logic [4:0]  shcnt_q, shcnt_d;
  logic [23:0] shd_bcd_q, shd_bcd_d;
  logic [5:0]  shd_pt_q, shd_pt_d;
  logic        shd_sgn_q, shd_sgn_d;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    wpt_d     = wpt_q;
    wsgn_d    = wsgn_q;
    shcnt_d   = shcnt_q;
    shd_bcd_d = shd_bcd_q;
    shd_pt_d  = shd_pt_q;
    shd_sgn_d = shd_sgn_q;
    case (state_q)
      ST_IDLE: begin
        bin_d   = (data > DATA_MAX) ? DATA_MAX : data;
        bcd_d   = '0;
        wpt_d   = point;
        wsgn_d  = sign;
        shcnt_d = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        shcnt_d        = shcnt_q + 5'd1;
        if (shcnt_q == 5'd19) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // value, point and sign land together so a slot never mixes frames
        shd_bcd_d = bcd_q;
        shd_pt_d  = wpt_q;
        shd_sgn_d = wsgn_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      wpt_q     <= '0;
      wsgn_q    <= 1'b0;
      shcnt_q   <= '0;
      shd_bcd_q <= '0;
      shd_pt_q  <= '0;
      shd_sgn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      wpt_q     <= wpt_d;
      wsgn_q    <= wsgn_d;
      shcnt_q   <= shcnt_d;
      shd_bcd_q <= shd_bcd_d;
      shd_pt_q  <= shd_pt_d;
      shd_sgn_q <= shd_sgn_d;
    end
  end

  // -------------------------------------------------- blanking / decode
  logic [2:0] msd, hpt, blank_b;
  logic [3:0] nib;
  logic [6:0] code;
  logic       dp_n;
  logic [5:0] sel_q, sel_d;
  logic [7:0] seg_q, seg_d;

  always_comb begin
    msd = '0;
    hpt = '0;
    nib = '0;
    for (int i = 0; i < 6; i++) begin
      if (shd_bcd_q[4*i +: 4] != 4'd0) msd = 3'(i);
      if (shd_pt_q[i])                 hpt = 3'(i);
      if (idx_q == 3'(i))              nib = shd_bcd_q[4*i +: 4];
    end
    // an all-zero frame leaves B at 0 so digit 0 still shows "0"
    blank_b = (msd > hpt) ? msd : hpt;
  end

  always_comb begin
    case (nib)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = 7'h7F;
    endcase
  end

  always_comb begin
    dp_n  = ~shd_pt_q[idx_q];
    sel_d = '0;
    seg_d = 8'hFF;
    if (seg_en) begin
      sel_d = 6'(1) << idx_q;
      if (idx_q <= blank_b)
        seg_d = {dp_n, code};
      else if (shd_sgn_q && (idx_q == blank_b + 3'd1))
        seg_d = {dp_n, 7'h3F};   // minus: g only; never reached when B=5
      else
        seg_d = {dp_n, 7'h7F};   // blank digit may still carry its DP
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel_q <= '0;
      seg_q <= 8'hFF;
    end else begin
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_dyn_scan_ctrl.sv
// Directed bench for seg_dyn_scan_ctrl with CNT_SCAN_MAX=9 (10-cycle slots).
// A small reference counter tracks edges since reset release to predict the
// scan index; per-digit segment values are hand-computed constants.
module tb_seg_dyn_scan_ctrl;
  localparam int SCAN = 9;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [19:0] data = '0;
  logic [5:0]  point = '0;
  logic        sign = 1'b0;
  logic        seg_en = 1'b1;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;
  logic en_s = 1'b0;

  always #10 sys_clk = ~sys_clk;

  seg_dyn_scan_ctrl #(.CNT_SCAN_MAX(SCAN)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data), .point(point),
    .sign(sign), .seg_en(seg_en), .sel(sel), .seg(seg)
  );

  // reference: edges since release and the seg_en value seen at each edge
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cyc  <= 0;
      en_s <= 1'b0;
    end else begin
      cyc  <= cyc + 1;
      en_s <= seg_en;
    end
  end

  function automatic int exp_idx();
    return (cyc < 1) ? 0 : ((cyc - 1) / (SCAN + 1)) % 6;
  endfunction

  function automatic logic [5:0] exp_sel();
    if (!en_s || cyc < 1) return 6'b0;
    return 6'(1) << exp_idx();
  endfunction

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      vecs++;
      assert ($onehot0(sel)) else begin
        errs++;
        $error("FAIL sel_onehot0: got %b exp at most one bit set", sel);
      end
    end
  end

  task automatic cmp8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cmp6(input string tag, input logic [5:0] got, input logic [5:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %b exp %b", tag, got, exp);
    end
  endtask

  // wait (bounded) for digit d to be selected, then check its segments
  task automatic digit(input int d, input logic [7:0] exp, input string tag);
    logic [5:0] one;
    int n;
    one = 6'(1) << d;
    n = 0;
    while (sel !== one && n < 80) begin
      @(negedge sys_clk);
      n++;
    end
    cmp6({tag, "_sel"}, sel, one);
    cmp8(tag, seg, exp);
  endtask

  task automatic check_all(input logic [5:0][7:0] e, input string tag);
    for (int i = 0; i < 6; i++) digit(i, e[i], $sformatf("%s_d%0d", tag, i));
  endtask

  task automatic settle();
    repeat (50) @(negedge sys_clk);
  endtask

  logic [5:0][7:0] t123456 = {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
  logic [5:0][7:0] c99     = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h90, 8'h90};
  logic [5:0][7:0] c100    = {8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0};

  initial begin
    // 1: reset values, then the all-zero frame with exact slot timing
    repeat (3) @(negedge sys_clk);
    cmp6("rst_sel", sel, 6'b0);
    cmp8("rst_seg", seg, 8'hFF);
    sys_rst_n = 1'b1;
    for (int k = 1; k <= 65; k++) begin
      @(negedge sys_clk);
      cmp6("t1_sel", sel, exp_sel());
      cmp8("t1_seg", seg, (exp_idx() == 0) ? 8'hC0 : 8'hFF);
    end

    // 2: full six-digit value
    data = 20'd123456;
    settle();
    check_all(t123456, "t2");

    // 3: minus sign after the leading digit, then dropped at full width
    data = 20'd42; sign = 1'b1;
    settle();
    check_all({8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h99, 8'hA4}, "t3a");
    data = 20'd999999;
    settle();
    check_all({6{8'h90}}, "t3b");

    // 4: decimal points extend the unblanked region
    sign = 1'b0; data = 20'd5; point = 6'b000010;
    settle();
    check_all({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40, 8'h92}, "t4a");
    data = 20'd0; point = 6'b100000;
    settle();
    check_all({8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}, "t4b");
    point = 6'b0;

    // 5: clamp, then a rapidly changing value must show whole frames only
    data = 20'hFFFFF;
    settle();
    check_all({6{8'h90}}, "t5_clamp");
    data = 20'd99;
    settle();
    for (int t = 0; t < 240; t++) begin
      int ix;
      if (t % 3 == 0) data = (data == 20'd99) ? 20'd100 : 20'd99;
      @(negedge sys_clk);
      ix = 0;
      for (int i = 0; i < 6; i++) if (sel[i]) ix = i;
      vecs++;
      assert (seg === c99[ix] || seg === c100[ix]) else begin
        errs++;
        $error("FAIL t5_atomic: got %h exp %h or %h (digit %0d)", seg, c99[ix], c100[ix], ix);
      end
    end

    // 6a: blank mid-slot; index keeps running underneath
    data = 20'd123456;
    settle();
    begin
      int n = 0;
      while (((cyc - 1) % (SCAN + 1)) != 4 && n < 20) begin
        @(negedge sys_clk);
        n++;
      end
    end
    seg_en = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge sys_clk);
      cmp6("t6_off_sel", sel, 6'b0);
      cmp8("t6_off_seg", seg, 8'hFF);
    end
    seg_en = 1'b1;
    @(negedge sys_clk);
    cmp6("t6_on_sel", sel, exp_sel());
    cmp8("t6_on_seg", seg, t123456[exp_idx()]);

    // 6b: reset while the converter is shifting
    begin
      int n = 0;
      while ((cyc % 22) != 5 && n < 30) begin
        @(negedge sys_clk);
        n++;
      end
      cmp6("t6_shift_phase", 6'(cyc % 22), 6'd5);
    end
    sys_rst_n = 1'b0;
    #1;
    cmp6("t6_rst_sel", sel, 6'b0);
    cmp8("t6_rst_seg", seg, 8'hFF);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge sys_clk);
      cmp6("t6_post_sel", sel, exp_sel());
      if (k <= 22) cmp8("t6_post_seg", seg, (exp_idx() == 0) ? 8'hC0 : 8'hFF);
      else         cmp8("t6_first_load", seg, t123456[exp_idx()]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
